mem_controller: RTL
===================

# mem_controller

Multicycle-datapath memory controller: accepts one load/store request per transaction from the control FSM (address taken from MAR, store data from MDR) and runs it on the single-port memory bus with a req/ack handshake. It returns aligned, sign/zero-extended load data for loading into MDR/IR, along with a one-cycle response strobe. Misaligned accesses and bus timeouts complete with an error flag.

## Interface
- ADDR_WIDTH, 32, byte address width; data path fixed at 32 bits
- TIMEOUT, 255, maximum cycles mem_req is held without mem_ack; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when set, sign-extends when clear
- req_addr  in  ADDR_WIDTH  byte address (from MAR)
- req_wdata  in  32  store data, LSB-justified (from MDR)
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or timeout; valid only with rsp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_WIDTH  word address (req_addr with bits [1:0] forced to 0)
- mem_wdata  out  32  store data replicated into byte lanes
- mem_be  out  4  byte enables; 4'b1111 for loads
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle
- mem_rdata  in  32  bus read word

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready = 1. The request is accepted on req_valid && req_ready, and all request fields are registered.
  - Accepted and legal: go to BUS.
  - Accepted and illegal: go to RESP with the error set; no bus cycle is issued.
- Legality rules:
  - size 3 is illegal.
  - Half with addr[0] = 1 is illegal.
  - Word with addr[1:0] != 0 is illegal.
- BUS: mem_req = 1, and all mem_* outputs stay stable until mem_ack is seen.
  - On mem_ack: capture the extracted data and go to RESP.
  - On timeout: go to RESP with the error set.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Stores:
  - Byte: mem_be = 1 << addr[1:0], and wdata[7:0] is replicated to all four lanes.
  - Half: mem_be = 4'b0011 << addr[1:0], and wdata[15:0] is replicated to both halves.
  - Word: mem_be = 4'b1111.
- Loads: select the byte or half at addr[1:0] from mem_rdata, then extend to 32 bits per req_unsigned.
- Timeout counter:
  - Clears on entry to BUS and increments each BUS cycle without mem_ack.
  - After TIMEOUT consecutive BUS cycles without ack, go to RESP with the error set.
  - If mem_ack arrives in the final counted cycle, the ack wins and the response has no error.
- mem_ack outside BUS is ignored.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0
- All outputs are registered or decoded from registered state; no input-to-output combinational path exists except none.
- Minimum latency, with the request accepted at cycle 0:
  - mem_req is high in cycle 1.
  - mem_ack in cycle 1 gives rsp_valid in cycle 2.
  - req_ready is high again in cycle 3.
- Error without a bus cycle: accept at cycle 0, rsp_valid with rsp_err in cycle 1.
- Timeout: mem_req is high for cycles 1..TIMEOUT; rsp_err is asserted in cycle TIMEOUT+1 with mem_req = 0.
- Asserting rst in any state aborts the transaction immediately: mem_req drops asynchronously and no response is produced.
- req_valid held high through RESP is not accepted until IDLE; there are no back-to-back accepts.

## Structure
- Package mem_pkg provides:
  - mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD)
  - mem_state_t enum (IDLE, BUS, RESP)
  - function is_aligned(size, addr[1:0])
- Sub-module mem_lane_align (combinational) handles:
  - store lane replication and byte-enable generation
  - load byte/half extraction and extension
- It is instantiated once; the FSM and timeout counter live in mem_controller.

## Test plan
- Word load at 0x100, mem_rdata = 0xDEADBEEF, ack on first BUS cycle:
  - mem_addr = 0x100, mem_be = 4'hF
  - rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid in cycle 2
- Signed byte load at 0x203, mem_rdata = 0x80112233:
  - rsp_rdata = 0xFFFFFF80
  - With req_unsigned set, rsp_rdata = 0x00000080
- Half store of 0x0000ABCD at 0x302:
  - mem_addr = 0x300, mem_be = 4'b1100, mem_wdata = 0xABCDABCD
  - outputs held stable across 3 wait cycles before ack
- Misaligned word load at 0x101, then size = 3:
  - each gives rsp_err = 1 in cycle 1, with mem_req never asserted
- TIMEOUT = 4, no ack:
  - mem_req high for exactly 4 cycles, rsp_err in cycle 5
  - a second run with ack in cycle 4 completes with no error
- rst asserted mid-BUS:
  - mem_req = 0 immediately and no rsp_valid
  - after release, req_ready = 1 and a new load completes normally

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the multicycle memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Natural alignment check; size 3 is never legal.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = ~off[0];
      MEM_WORD: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_controller_if.sv
// CPU request/response and memory bus signals for mem_controller.
interface mem_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  // Controller side: owns the bus and the response.
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // CPU / memory side.
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Loads always read the full word; only stores narrow the enables.
  always_comb begin
    be        = 4'hF;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      MEM_BYTE: begin
        wdata_rep = {4{wdata[7:0]}};
        if (we) be = 4'b0001 << off;
        rdata_ext = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_HALF: begin
        wdata_rep = {2{wdata[15:0]}};
        if (we) be = 4'b0011 << off;
        rdata_ext = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        wdata_rep = wdata;
        be        = 4'hF;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Load/store controller: one request per transaction, req/ack memory bus, timeout and alignment errors.
module mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_controller_if.master bus
);

  localparam int unsigned AW      = ADDR_WIDTH;
  localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;

  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;

  logic             in_idle;
  logic             al_we;
  logic [1:0]       al_size;
  logic [1:0]       al_off;
  logic             al_uns;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;
  logic             timeout_hit;

  // Aligner sees the incoming request in IDLE and the captured one afterwards.
  assign in_idle = (state_q == IDLE);
  assign al_we   = in_idle ? bus.req_we           : we_q;
  assign al_size = in_idle ? bus.req_size         : size_q;
  assign al_off  = in_idle ? bus.req_addr[1:0]    : off_q;
  assign al_uns  = in_idle ? bus.req_unsigned     : uns_q;

  mem_lane_align u_align (
    .we        (al_we),
    .size      (al_size),
    .off       (al_off),
    .uns       (al_uns),
    .wdata     (bus.req_wdata),
    .rdata     (bus.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          off_d       = bus.req_addr[1:0];
          req_ready_d = 1'b0;
          if (is_aligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d     = BUS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[AW-1:2], 2'b00};
            mem_wdata_d = al_wdata;
            mem_be_d    = al_be;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      BUS: begin
        // An ack in the last counted cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : al_rdata;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule
